// File: rtl/axi_atop_resp_inject_pkg.sv
// Shared types and constants for the ATOP response injector.
package axi_atop_resp_inject_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [7:0] len_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Default channel layouts used when the parent does not override them.
  typedef struct packed {
    logic [3:0] id;
    resp_t      resp;
    logic [0:0] user;
  } b_chan_def_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    resp_t       resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_def_t;

  // Which of the two sources currently owns an upstream channel.
  typedef enum logic {
    SRC_DN  = 1'b0,
    SRC_INJ = 1'b1
  } src_e;

endpackage

// File: rtl/axi_atop_resp_inject_arb2.sv
// Two-way round-robin arbiter between the downstream and injected sources,
// with grant hold during stalls and an optional lock until the last beat.
module axi_atop_resp_arb2
  import axi_atop_resp_inject_pkg::*;
#(
  parameter type chan_t     = r_chan_def_t,
  parameter bit  LockOnLast = 1'b0
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  chan_t i_dnData,
  input  logic  i_dnValid,
  input  logic  i_dnLast,
  output logic  o_dnReady,
  input  chan_t i_injData,
  input  logic  i_injValid,
  input  logic  i_injLast,
  output logic  o_injReady,
  output chan_t o_data,
  output logic  o_valid,
  input  logic  i_ready
);

  src_e r_prio;
  logic r_hold;
  src_e r_holdSrc;
  logic r_lock;
  src_e r_lockSrc;

  src_e w_sel;
  logic w_selValid;
  logic w_selLast;
  logic w_hs;

  // Pick the owner: a burst lock beats a stall hold, which beats round-robin.
  always_comb begin
    w_sel = SRC_DN;
    if (r_lock) begin
      w_sel = r_lockSrc;
    end else if (r_hold) begin
      w_sel = r_holdSrc;
    end else if (i_dnValid && i_injValid) begin
      w_sel = r_prio;
    end else if (i_injValid) begin
      w_sel = SRC_INJ;
    end
    w_selValid = (w_sel == SRC_INJ) ? i_injValid : i_dnValid;
    w_selLast  = (w_sel == SRC_INJ) ? i_injLast  : i_dnLast;
    o_data     = (w_sel == SRC_INJ) ? i_injData  : i_dnData;
    o_valid    = w_selValid;
    o_dnReady  = (w_sel == SRC_DN)  && i_dnValid  && i_ready;
    o_injReady = (w_sel == SRC_INJ) && i_injValid && i_ready;
    w_hs       = w_selValid && i_ready;
  end

  // Track stall hold, burst lock and which source gets the next tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prio    <= SRC_INJ;
      r_hold    <= 1'b0;
      r_holdSrc <= SRC_DN;
      r_lock    <= 1'b0;
      r_lockSrc <= SRC_DN;
    end else begin
      r_hold    <= w_selValid && !i_ready;
      r_holdSrc <= w_sel;
      if (w_hs) begin
        if (LockOnLast) begin
          r_lock    <= !w_selLast;
          r_lockSrc <= w_sel;
        end
        if (!LockOnLast || w_selLast) begin
          r_prio <= (w_sel == SRC_INJ) ? SRC_DN : SRC_INJ;
        end
      end
    end
  end

endmodule

// File: rtl/axi_atop_resp_inject.sv
// Injects SLVERR B/R responses for filtered atomics and shares the upstream
// B and R channels with responses forwarded from downstream.
module axi_atop_resp_inject
  import axi_atop_resp_inject_pkg::*;
#(
  parameter int unsigned IdWidth  = 4,
  parameter type         b_chan_t = b_chan_def_t,
  parameter type         r_chan_t = r_chan_def_t
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [IdWidth-1:0] cmd_id_i,
  input  len_t               cmd_len_i,
  input  logic               cmd_r_i,
  input  b_chan_t            dn_b_i,
  input  logic               dn_b_valid_i,
  output logic               dn_b_ready_o,
  input  r_chan_t            dn_r_i,
  input  logic               dn_r_valid_i,
  output logic               dn_r_ready_o,
  output b_chan_t            up_b_o,
  output logic               up_b_valid_o,
  input  logic               up_b_ready_i,
  output r_chan_t            up_r_o,
  output logic               up_r_valid_o,
  input  logic               up_r_ready_i
);

  logic               r_bPend;
  logic               r_rBusy;
  logic [IdWidth-1:0] r_id;
  len_t               r_cnt;

  logic    w_cmdHs;
  logic    w_injBReady;
  logic    w_injRReady;
  b_chan_t w_injB;
  r_chan_t w_injR;

  assign cmd_ready_o = !r_bPend && !r_rBusy;
  assign w_cmdHs     = cmd_valid_i && cmd_ready_o;

  // Build the error responses from the latched command.
  always_comb begin
    w_injB      = '0;
    w_injB.id   = r_id;
    w_injB.resp = RESP_SLVERR;
    w_injR      = '0;
    w_injR.id   = r_id;
    w_injR.resp = RESP_SLVERR;
    w_injR.last = (r_cnt == '0);
  end

  // Command register: accept only when both injections are finished.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bPend <= 1'b0;
      r_rBusy <= 1'b0;
      r_id    <= '0;
      r_cnt   <= '0;
    end else if (w_cmdHs) begin
      r_bPend <= 1'b1;
      r_id    <= cmd_id_i;
      if (cmd_r_i) begin
        r_rBusy <= 1'b1;
        r_cnt   <= cmd_len_i;
      end
    end else begin
      if (w_injBReady) begin
        r_bPend <= 1'b0;
      end
      if (w_injRReady) begin
        if (r_cnt == '0) begin
          r_rBusy <= 1'b0;
        end else begin
          r_cnt <= r_cnt - len_t'(1);
        end
      end
    end
  end

  axi_atop_resp_arb2 #(
    .chan_t     (b_chan_t),
    .LockOnLast (1'b0)
  ) u_bArb (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_dnData   (dn_b_i),
    .i_dnValid  (dn_b_valid_i),
    .i_dnLast   (1'b1),
    .o_dnReady  (dn_b_ready_o),
    .i_injData  (w_injB),
    .i_injValid (r_bPend),
    .i_injLast  (1'b1),
    .o_injReady (w_injBReady),
    .o_data     (up_b_o),
    .o_valid    (up_b_valid_o),
    .i_ready    (up_b_ready_i)
  );

  axi_atop_resp_arb2 #(
    .chan_t     (r_chan_t),
    .LockOnLast (1'b1)
  ) u_rArb (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_dnData   (dn_r_i),
    .i_dnValid  (dn_r_valid_i),
    .i_dnLast   (dn_r_i.last),
    .o_dnReady  (dn_r_ready_o),
    .i_injData  (w_injR),
    .i_injValid (r_rBusy),
    .i_injLast  (w_injR.last),
    .o_injReady (w_injRReady),
    .o_data     (up_r_o),
    .o_valid    (up_r_valid_o),
    .i_ready    (up_r_ready_i)
  );

endmodule

// File: tb/tb_axi_atop_resp_inject.sv
// Scoreboard bench for the ATOP response injector: drivers push expected
// beats per source, a negedge monitor pops and compares upstream handshakes.
module tb_axi_atop_resp_inject;
  import axi_atop_resp_inject_pkg::*;

  typedef b_chan_def_t bT;
  typedef r_chan_def_t rT;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [3:0] cmd_id_i = '0;
  len_t       cmd_len_i = '0;
  logic       cmd_r_i = 1'b0;
  bT          dn_b_i = '0;
  logic       dn_b_valid_i = 1'b0;
  logic       dn_b_ready_o;
  rT          dn_r_i = '0;
  logic       dn_r_valid_i = 1'b0;
  logic       dn_r_ready_o;
  bT          up_b_o;
  logic       up_b_valid_o;
  logic       up_b_ready_i = 1'b0;
  rT          up_r_o;
  logic       up_r_valid_o;
  logic       up_r_ready_i = 1'b0;

  axi_atop_resp_inject #(
    .IdWidth  (4),
    .b_chan_t (bT),
    .r_chan_t (rT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_id_i     (cmd_id_i),
    .cmd_len_i    (cmd_len_i),
    .cmd_r_i      (cmd_r_i),
    .dn_b_i       (dn_b_i),
    .dn_b_valid_i (dn_b_valid_i),
    .dn_b_ready_o (dn_b_ready_o),
    .dn_r_i       (dn_r_i),
    .dn_r_valid_i (dn_r_valid_i),
    .dn_r_ready_o (dn_r_ready_o),
    .up_b_o       (up_b_o),
    .up_b_valid_o (up_b_valid_o),
    .up_b_ready_i (up_b_ready_i),
    .up_r_o       (up_r_o),
    .up_r_valid_o (up_r_valid_o),
    .up_r_ready_i (up_r_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int unsigned gapPct = 0;
  int upBMode = 1;
  int upRMode = 1;
  int dnRBeats = 0;

  bT    dnBQ[$];
  rT    dnRQ[$];
  bT    expBInj[$];
  bT    expBDn[$];
  rT    expRInj[$];
  rT    expRDn[$];
  bT    bLog[$];
  rT    rLog[$];
  src_e bSrcLog[$];
  src_e rSrcLog[$];

  logic rOpen = 1'b0;
  src_e rOpenSrc = SRC_DN;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic pickReady(input int mode);
    if (mode == 2) return ($urandom_range(99) < 60);
    return (mode == 1);
  endfunction

  // Reference model: an accepted command yields one SLVERR B and, for
  // load/compare atomics, len+1 SLVERR R beats with last only on the final one.
  task automatic pushInj(input logic [3:0] id, input len_t len, input logic r);
    bT b;
    rT rb;
    b = '0;
    b.id = id;
    b.resp = RESP_SLVERR;
    expBInj.push_back(b);
    if (r) begin
      for (int i = 0; i <= int'(len); i++) begin
        rb = '0;
        rb.id = id;
        rb.resp = RESP_SLVERR;
        rb.last = (i == int'(len));
        expRInj.push_back(rb);
      end
    end
  endtask

  task automatic pushDnB(input logic [3:0] id);
    bT b;
    b = '0;
    b.id = id;
    b.resp = RESP_OKAY;
    b.user = 1'($urandom_range(1));
    dnBQ.push_back(b);
    expBDn.push_back(b);
  endtask

  task automatic pushDnR(input logic [3:0] id, input int len);
    rT rb;
    for (int i = 0; i <= len; i++) begin
      rb = '0;
      rb.id = id;
      rb.data = $urandom;
      rb.resp = RESP_OKAY;
      rb.last = (i == len);
      rb.user = 1'($urandom_range(1));
      dnRQ.push_back(rb);
      expRDn.push_back(rb);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] id, input len_t len, input logic r);
    int waitCnt;
    waitCnt = 0;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1;
    cmd_id_i = id;
    cmd_len_i = len;
    cmd_r_i = r;
    @(negedge clk_i);
    while (!cmd_ready_o && waitCnt < 5000) begin
      waitCnt++;
      @(negedge clk_i);
    end
    if (!cmd_ready_o) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL cmdAccept: got ready=0 after %0d cycles, expected ready=1", waitCnt);
      cmd_valid_i = 1'b0;
    end else begin
      pushInj(id, len, r);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic applyReset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int c;
    int left;
    c = 0;
    left = expBInj.size() + expBDn.size() + expRInj.size() + expRDn.size();
    while (left != 0 && c < 20000) begin
      @(negedge clk_i);
      c++;
      left = expBInj.size() + expBDn.size() + expRInj.size() + expRDn.size();
    end
    checkOutput({name, "_pendingBeats"}, 64'(left), 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic scoreB(input bT got);
    src_e src;
    bT exp;
    src = (got.resp == RESP_SLVERR) ? SRC_INJ : SRC_DN;
    bLog.push_back(got);
    bSrcLog.push_back(src);
    if (src == SRC_INJ) begin
      if (expBInj.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL injB: got unexpected beat %0h, expected none", got);
      end else begin
        exp = expBInj.pop_front();
        checkOutput("injB", 64'(got), 64'(exp));
      end
    end else begin
      if (expBDn.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL dnB: got unexpected beat %0h, expected none", got);
      end else begin
        exp = expBDn.pop_front();
        checkOutput("dnB", 64'(got), 64'(exp));
      end
    end
  endtask

  task automatic scoreR(input rT got);
    src_e src;
    rT exp;
    src = (got.resp == RESP_SLVERR) ? SRC_INJ : SRC_DN;
    rLog.push_back(got);
    rSrcLog.push_back(src);
    if (src == SRC_DN) dnRBeats++;
    if (rOpen) checkOutput("rBurstContig", 64'(src), 64'(rOpenSrc));
    rOpen = !got.last;
    rOpenSrc = src;
    if (src == SRC_INJ) begin
      if (expRInj.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL injR: got unexpected beat %0h, expected none", got);
      end else begin
        exp = expRInj.pop_front();
        checkOutput("injR", 64'(got), 64'(exp));
      end
    end else begin
      if (expRDn.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL dnR: got unexpected beat %0h, expected none", got);
      end else begin
        exp = expRDn.pop_front();
        checkOutput("dnR", 64'(got), 64'(exp));
      end
    end
  endtask

  // Monitor: checks stall stability, then scores every upstream handshake.
  initial begin : monitor
    logic bStall;
    logic rStall;
    bT    bHeld;
    rT    rHeld;
    bStall = 1'b0;
    rStall = 1'b0;
    bHeld = '0;
    rHeld = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        bStall = 1'b0;
        rStall = 1'b0;
        rOpen = 1'b0;
      end else begin
        if (bStall) begin
          checkOutput("bHoldValid", 64'(up_b_valid_o), 64'd1);
          checkOutput("bHoldPayload", 64'(up_b_o), 64'(bHeld));
        end
        if (rStall) begin
          checkOutput("rHoldValid", 64'(up_r_valid_o), 64'd1);
          checkOutput("rHoldPayload", 64'(up_r_o), 64'(rHeld));
        end
        if (up_b_valid_o && up_b_ready_i) scoreB(up_b_o);
        if (up_r_valid_o && up_r_ready_i) scoreR(up_r_o);
        bStall = up_b_valid_o && !up_b_ready_i;
        rStall = up_r_valid_o && !up_r_ready_i;
        bHeld = up_b_o;
        rHeld = up_r_o;
      end
    end
  end

  // Upstream ready generator: forced low, forced high or random per channel.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      up_b_ready_i = pickReady(upBMode);
      up_r_ready_i = pickReady(upRMode);
    end
  end

  // Downstream B driver: holds each beat valid until it is accepted.
  initial begin
    int waitCnt;
    @(posedge clk_i); #1;
    forever begin
      if (dnBQ.size() != 0 && !rst_i && $urandom_range(99) >= gapPct) begin
        dn_b_i = dnBQ.pop_front();
        dn_b_valid_i = 1'b1;
        waitCnt = 0;
        @(negedge clk_i);
        while (!dn_b_ready_o && waitCnt < 5000) begin
          waitCnt++;
          @(negedge clk_i);
        end
        if (!dn_b_ready_o) begin
          vectors++; miscompares++;
          $display("[TB] FAIL dnBAccept: got ready=0 after %0d cycles, expected ready=1", waitCnt);
        end
        @(posedge clk_i); #1;
      end else begin
        dn_b_valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
    end
  end

  // Downstream R driver: same handshake discipline, beats may have gaps.
  initial begin
    int waitCnt;
    @(posedge clk_i); #1;
    forever begin
      if (dnRQ.size() != 0 && !rst_i && $urandom_range(99) >= gapPct) begin
        dn_r_i = dnRQ.pop_front();
        dn_r_valid_i = 1'b1;
        waitCnt = 0;
        @(negedge clk_i);
        while (!dn_r_ready_o && waitCnt < 5000) begin
          waitCnt++;
          @(negedge clk_i);
        end
        if (!dn_r_ready_o) begin
          vectors++; miscompares++;
          $display("[TB] FAIL dnRAccept: got ready=0 after %0d cycles, expected ready=1", waitCnt);
        end
        @(posedge clk_i); #1;
      end else begin
        dn_r_valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
    end
  end

  // Directed scenarios followed by a randomized mixed-traffic run.
  initial begin
    int cnt;
    int lastCnt;
    int rvCnt;
    int injIdx;
    rT  rb;
    bT  bb;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    checkOutput("rstBValid", 64'(up_b_valid_o), 64'd0);
    checkOutput("rstRValid", 64'(up_r_valid_o), 64'd0);
    checkOutput("rstCmdReady", 64'(cmd_ready_o), 64'd1);
    checkOutput("rstDnReady", 64'({dn_b_ready_o, dn_r_ready_o}), 64'd0);
    checkOutput("rstNoX", 64'($isunknown({cmd_ready_o, dn_b_ready_o, dn_r_ready_o,
                up_b_o, up_b_valid_o, up_r_o, up_r_valid_o})), 64'd0);

    // Basic injection with latency and cmd_ready return timing
    upBMode = 1; upRMode = 1; gapPct = 0;
    repeat (2) @(posedge clk_i);
    rLog.delete();
    applyStimulus(4'd3, 8'd3, 1'b1);
    @(negedge clk_i);
    checkOutput("t2_bLatency", 64'(up_b_valid_o), 64'd1);
    checkOutput("t2_rLatency", 64'(up_r_valid_o), 64'd1);
    cnt = 1;
    while (!cmd_ready_o && cnt < 50) begin
      @(negedge clk_i);
      cnt++;
    end
    checkOutput("t2_cmdReadyCycle", 64'(cnt), 64'd5);
    waitIdle("t2");
    lastCnt = 0;
    foreach (rLog[i]) if (rLog[i].last) lastCnt++;
    checkOutput("t2_rBeats", 64'(rLog.size()), 64'd4);
    checkOutput("t2_lastCount", 64'(lastCnt), 64'd1);

    // Longest burst: 256 beats without counter wrap
    rLog.delete();
    applyStimulus(4'd9, 8'd255, 1'b1);
    waitIdle("len255");
    lastCnt = 0;
    foreach (rLog[i]) if (rLog[i].last) lastCnt++;
    checkOutput("len255_beats", 64'(rLog.size()), 64'd256);
    checkOutput("len255_lastCount", 64'(lastCnt), 64'd1);

    // Injection arriving mid downstream burst waits for its last beat
    rLog.delete(); rSrcLog.delete();
    dnRBeats = 0;
    pushDnR(4'd5, 7);
    cnt = 0;
    while (dnRBeats < 2 && cnt < 200) begin
      @(negedge clk_i);
      cnt++;
    end
    applyStimulus(4'd2, 8'd0, 1'b1);
    waitIdle("t3");
    injIdx = -1;
    foreach (rSrcLog[i]) if (rSrcLog[i] == SRC_INJ && injIdx < 0) injIdx = i;
    checkOutput("t3_injPosition", 64'(injIdx), 64'd8);
    checkOutput("t3_rBeats", 64'(rLog.size()), 64'd9);

    // B round-robin after reset: injected first, then downstream, twice
    applyReset();
    upBMode = 1;
    bLog.delete(); bSrcLog.delete();
    repeat (2) begin
      fork
        applyStimulus(4'd4, 8'd0, 1'b0);
        begin
          @(posedge clk_i);
          @(negedge clk_i);
          pushDnB(4'd1);
        end
      join
      waitIdle("t4");
    end
    checkOutput("t4_bBeats", 64'(bLog.size()), 64'd4);
    for (int i = 0; i < 4 && i < bLog.size(); i++) begin
      bb = bLog[i];
      checkOutput($sformatf("t4_order%0d", i), 64'(bb.id), (i % 2 == 0) ? 64'd4 : 64'd1);
    end

    // Grant hold during an upstream R stall
    upRMode = 0;
    repeat (2) @(posedge clk_i);
    rLog.delete(); rSrcLog.delete();
    applyStimulus(4'd6, 8'd0, 1'b1);
    repeat (5) @(posedge clk_i);
    pushDnR(4'd8, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("t5_stallValid", 64'(up_r_valid_o), 64'd1);
    checkOutput("t5_stallResp", 64'(up_r_o.resp), 64'(RESP_SLVERR));
    upRMode = 1;
    waitIdle("t5");
    checkOutput("t5_rBeats", 64'(rSrcLog.size()), 64'd2);
    if (rSrcLog.size() == 2) begin
      checkOutput("t5_first", 64'(rSrcLog[0]), 64'(SRC_INJ));
      checkOutput("t5_second", 64'(rSrcLog[1]), 64'(SRC_DN));
    end

    // B-only command stalls the next command until its B handshakes
    upBMode = 0;
    repeat (2) @(posedge clk_i);
    bLog.delete(); rLog.delete();
    applyStimulus(4'd7, 8'd255, 1'b0);
    cnt = 0; rvCnt = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (cmd_ready_o) cnt++;
      if (up_r_valid_o) rvCnt++;
    end
    checkOutput("t6_cmdStalled", 64'(cnt), 64'd0);
    checkOutput("t6_noRValid", 64'(rvCnt), 64'd0);
    upBMode = 1;
    applyStimulus(4'd11, 8'd0, 1'b0);
    waitIdle("t6");
    checkOutput("t6_bBeats", 64'(bLog.size()), 64'd2);
    checkOutput("t6_rBeats", 64'(rLog.size()), 64'd0);
    if (bLog.size() != 0) begin
      bb = bLog[0];
      checkOutput("t6_firstId", 64'(bb.id), 64'd7);
    end

    // Randomized mixed traffic
    upBMode = 2; upRMode = 2; gapPct = 30;
    fork
      begin
        repeat (600) begin
          repeat ($urandom_range(3)) @(posedge clk_i);
          applyStimulus(4'($urandom_range(15)), len_t'($urandom_range(15)), 1'($urandom_range(1)));
        end
      end
      begin
        repeat (600) begin
          @(posedge clk_i); #1;
          pushDnB(4'($urandom_range(15)));
          repeat ($urandom_range(12)) @(posedge clk_i);
        end
      end
      begin
        repeat (300) begin
          @(posedge clk_i); #1;
          pushDnR(4'($urandom_range(15)), $urandom_range(15));
          repeat ($urandom_range(20)) @(posedge clk_i);
        end
      end
    join
    waitIdle("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
